// File: rtl/bcd_disp_mux_pkg.sv
// ---------------------------------------------------------------------------
// bcd_disp_mux_pkg
//   Shared definitions for the 3-digit seven-segment display multiplexer:
//   digit-select state encoding and active-low segment patterns
//   (bit order g,f,e,d,c,b,a).
// ---------------------------------------------------------------------------
package bcd_disp_mux_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2
  } dig_sel_e;

  localparam logic [6:0] SSEG_0     = 7'h40;
  localparam logic [6:0] SSEG_1     = 7'h79;
  localparam logic [6:0] SSEG_2     = 7'h24;
  localparam logic [6:0] SSEG_3     = 7'h30;
  localparam logic [6:0] SSEG_4     = 7'h19;
  localparam logic [6:0] SSEG_5     = 7'h12;
  localparam logic [6:0] SSEG_6     = 7'h02;
  localparam logic [6:0] SSEG_7     = 7'h78;
  localparam logic [6:0] SSEG_8     = 7'h00;
  localparam logic [6:0] SSEG_9     = 7'h10;
  localparam logic [6:0] SSEG_DASH  = 7'h3F;
  localparam logic [6:0] SSEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_disp_mux_bcd_to_sseg.sv
// ---------------------------------------------------------------------------
// bcd_to_sseg
//   Combinational BCD to active-low seven-segment decoder.
//   Ports:
//     bcd_i   [3:0]  BCD digit; codes 10..15 render as a dash
//     blank_i        force all segments off
//     seg_o   [6:0]  active-low segments g,f,e,d,c,b,a
// ---------------------------------------------------------------------------
module bcd_to_sseg
  import bcd_disp_mux_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SSEG_DASH;
    if (blank_i) begin
      seg_o = SSEG_BLANK;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SSEG_0;
        4'd1:    seg_o = SSEG_1;
        4'd2:    seg_o = SSEG_2;
        4'd3:    seg_o = SSEG_3;
        4'd4:    seg_o = SSEG_4;
        4'd5:    seg_o = SSEG_5;
        4'd6:    seg_o = SSEG_6;
        4'd7:    seg_o = SSEG_7;
        4'd8:    seg_o = SSEG_8;
        4'd9:    seg_o = SSEG_9;
        default: seg_o = SSEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_disp_mux.sv
// ---------------------------------------------------------------------------
// bcd_disp_mux
//   Time-multiplexed 3-digit common-anode seven-segment driver. Each digit is
//   lit for DIV cycles; inputs are snapshotted once per 3*DIV-cycle frame so
//   the display never tears, and frame_tick pulses for the first cycle of
//   each new frame.
//   Parameters:
//     DIV            cycles per digit (>= 2)
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     in0/in1/in2    BCD units/tens/hundreds digits
//     dp_in  [2:0]   decimal point request per digit, active-high
//     an     [2:0]   digit anodes, active-low
//     sseg   [7:0]   segments, active-low; [7]=dp, [6:0]=g..a
//     frame_tick     one-cycle pulse when a new snapshot is taken
//   Build option:
//     LEADING_ZERO_BLANK_EN  blank leading zeros on digits 2 and 1
// ---------------------------------------------------------------------------
module bcd_disp_mux
  import bcd_disp_mux_pkg::*;
#(
  parameter int unsigned DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [2:0] dp_in,
  output logic [2:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  dig_sel_e         sel_q, sel_d;
  logic [3:0]       sh0_q, sh1_q, sh2_q;
  logic [2:0]       shdp_q;
  logic             snap;
  logic             lz1, lz2;
  logic [3:0]       digit;
  logic             blank;
  logic             dp_on;
  logic [6:0]       seg;
  logic [2:0]       an_d;
  logic [7:0]       sseg_d;
  logic [2:0]       an_q;
  logic [7:0]       sseg_q;
  logic             frame_tick_q;

  // Refresh counter
  assign tick  = (cnt_q == CNT_W'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Digit-select FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sel_q <= DIG0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  // Digit-select FSM: next state; an illegal encoding falls back to DIG0
  always_comb begin
    sel_d = sel_q;
    if (tick) begin
      case (sel_q)
        DIG0:    sel_d = DIG1;
        DIG1:    sel_d = DIG2;
        default: sel_d = DIG0;
      endcase
    end
  end

  // Snapshot at the DIG2 -> DIG0 boundary so a whole frame shows one value
  assign snap = tick && (sel_q == DIG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh0_q        <= '0;
      sh1_q        <= '0;
      sh2_q        <= '0;
      shdp_q       <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= snap;
      if (snap) begin
        sh0_q  <= in0;
        sh1_q  <= in1;
        sh2_q  <= in2;
        shdp_q <= dp_in;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign lz2 = (sh2_q == 4'd0);
  assign lz1 = (sh2_q == 4'd0) && (sh1_q == 4'd0);
`else
  assign lz2 = 1'b0;
  assign lz1 = 1'b0;
`endif

  // Digit-select FSM: output decode for the currently selected digit
  always_comb begin
    digit = '0;
    blank = 1'b1;
    dp_on = 1'b0;
    an_d  = '1;
    case (sel_q)
      DIG0: begin
        digit = sh0_q;
        blank = 1'b0;
        dp_on = shdp_q[0];
        an_d  = 3'b110;
      end
      DIG1: begin
        digit = sh1_q;
        blank = lz1;
        dp_on = shdp_q[1];
        an_d  = 3'b101;
      end
      DIG2: begin
        digit = sh2_q;
        blank = lz2;
        dp_on = shdp_q[2];
        an_d  = 3'b011;
      end
      default: ;
    endcase
    sseg_d = {~dp_on, seg};
  end

  bcd_to_sseg u_dec (
    .bcd_i   (digit),
    .blank_i (blank),
    .seg_o   (seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q   <= '1;
      sseg_q <= '1;
    end else begin
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// ---------------------------------------------------------------------------
// tb_bcd_disp_mux
//   Directed bench for bcd_disp_mux with DIV=4 (12-cycle frames).
//   Honours LEADING_ZERO_BLANK_EN for the expected leading-zero patterns.
// ---------------------------------------------------------------------------
module tb_bcd_disp_mux;

  logic       clk;
  logic       rst_n;
  logic [3:0] in0, in1, in2;
  logic [2:0] dp_in;
  logic [2:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  int unsigned total;
  int unsigned bad;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  bcd_disp_mux #(.DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .dp_in      (dp_in),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " an"},   {5'b0, an},         8'h07);
    chk({tag, " sseg"}, sseg,               8'hFF);
    chk({tag, " ft"},   {7'b0, frame_tick}, 8'h00);
  endtask

  // Check frame positions a..b (1..12, counted in negedges after the frame
  // starts): anode, segment pattern of digit (p-1)/4 and frame_tick at p=12.
  task automatic frame_part(input string tag, input int a, input int b,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2);
    logic [2:0] one;
    logic [2:0] ean;
    logic [7:0] es;
    int         idx;
    one = 3'b001;
    for (int p = a; p <= b; p++) begin
      @(negedge clk);
      idx = (p - 1) / 4;
      ean = ~(one << idx);
      es  = (idx == 0) ? e0 : (idx == 1) ? e1 : e2;
      chk($sformatf("%s p%0d an", tag, p),   {5'b0, an},         {5'b0, ean});
      chk($sformatf("%s p%0d sseg", tag, p), sseg,               es);
      chk($sformatf("%s p%0d ft", tag, p),   {7'b0, frame_tick}, {7'b0, (p == 12)});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    in2 = 4'd1; in1 = 4'd2; in0 = 4'd3;
    dp_in = 3'b000;

    #12;
    chk_reset("reset hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1: reset shadow (000, no dp)
    frame_part("f1", 1, 12, 8'hC0, LZ, LZ);

    // Frame 2: 1/2/3; inputs disturbed mid-frame must not tear the display
    frame_part("f2", 1, 5, 8'hB0, 8'hA4, 8'hF9);
    in0 = 4'd9;
    in2 = 4'd7;
    frame_part("f2", 6, 9, 8'hB0, 8'hA4, 8'hF9);
    in2 = 4'd1;
    frame_part("f2", 10, 12, 8'hB0, 8'hA4, 8'hF9);

    // Frame 3: new units digit 9 appears only now
    frame_part("f3", 1, 2, 8'h90, 8'hA4, 8'hF9);
    in1   = 4'hC;
    dp_in = 3'b010;
    frame_part("f3", 3, 12, 8'h90, 8'hA4, 8'hF9);

    // Frame 4: invalid tens digit renders as dash with its dp lit
    frame_part("f4", 1, 9, 8'h90, 8'h3F, 8'hF9);

    // Asynchronous reset during DIG2, observed without a clock edge
    rst_n = 1'b0;
    #1;
    chk_reset("async reset");
    in2 = 4'd0; in1 = 4'd0; in0 = 4'd7;
    dp_in = 3'b000;
    @(negedge clk);
    chk_reset("reset held");
    rst_n = 1'b1;

    // Restart from DIG0 with the cleared shadow
    frame_part("r1", 1, 12, 8'hC0, LZ, LZ);

    // 0/0/7 and load 0/5/0 for the next frame
    frame_part("r2", 1, 2, 8'hF8, LZ, LZ);
    in2 = 4'd0; in1 = 4'd5; in0 = 4'd0;
    frame_part("r2", 3, 12, 8'hF8, LZ, LZ);

    frame_part("r3", 1, 12, 8'hC0, 8'h92, LZ);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
